// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, start/busy/valid handshake.
// Optional MUL_DIV_FAST_MUL_EN swaps the iterative multiply for a single-cycle combinational one.
module mul_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  typedef struct packed {
    logic [2:0] op;
    logic       neg_res;
    logic       neg_rem;
  } ctl_t;

  state_t            state;
  ctl_t              ctl;
  logic [XLEN-1:0]   bmag;
  logic [2*XLEN-1:0] acc;   // MUL: {partial hi, multiplier}; DIV: {remainder, quotient}
  logic [CW-1:0]     cnt;

  logic            a_sgn, b_sgn, neg_a, neg_b, div_zero, div_ovf;
  logic [XLEN-1:0] a_mag, b_mag;
  always_comb begin
    a_sgn    = !(funct3[0] && (funct3[1] || funct3[2]));
    b_sgn    = funct3[2] ? !funct3[0] : !funct3[1];
    neg_a    = a_sgn && srcA[XLEN-1];
    neg_b    = b_sgn && srcB[XLEN-1];
    a_mag    = neg_a ? -srcA : srcA;
    b_mag    = neg_b ? -srcB : srcB;
    div_zero = (srcB == '0);
    div_ovf  = funct3[2] && !funct3[0] && (srcA == {1'b1, {(XLEN-1){1'b0}}}) && (srcB == '1);
  end

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic              div_ok;
  logic [2*XLEN-1:0] mul_next, div_next;
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, bmag} : '0);
    mul_next  = {mul_sum, acc[XLEN-1:1]};
    div_shift = acc[2*XLEN-1:XLEN-1];
    div_diff  = div_shift - {1'b0, bmag};
    div_ok    = !div_diff[XLEN];
    div_next  = {(div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]), acc[XLEN-2:0], div_ok};
  end

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   q_fix, r_fix, res_sel;
  always_comb begin
    prod_fix = ctl.neg_res ? -acc : acc;
    q_fix    = ctl.neg_res ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    r_fix    = ctl.neg_rem ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    res_sel  = '0;
    case (ctl.op)
      3'b000:                res_sel = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: res_sel = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:        res_sel = q_fix;
      default:               res_sel = r_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      ctl    <= '0;
      bmag   <= '0;
      acc    <= '0;
      cnt    <= '0;
      busy   <= 1'b0;
      valid  <= 1'b0;
      result <= '0;
    end else begin
      valid <= 1'b0;
      if (state != IDLE && flush) begin
        state <= IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: if (start && !flush) begin
            ctl.op      <= funct3;
            ctl.neg_res <= neg_a ^ neg_b;
            ctl.neg_rem <= neg_a;
            bmag        <= b_mag;
            cnt         <= '0;
            busy        <= 1'b1;
            if (funct3[2]) begin
              // Special divides preload {remainder, quotient} with the final unsigned answer.
              if (div_zero) begin
                acc         <= {srcA, {XLEN{1'b1}}};
                ctl.neg_res <= 1'b0;
                ctl.neg_rem <= 1'b0;
                state       <= DONE;
              end else if (div_ovf) begin
                acc         <= {{XLEN{1'b0}}, srcA};
                ctl.neg_res <= 1'b0;
                ctl.neg_rem <= 1'b0;
                state       <= DONE;
              end else begin
                acc   <= {{XLEN{1'b0}}, a_mag};
                state <= DIV;
              end
            end else begin
`ifdef MUL_DIV_FAST_MUL_EN
              acc   <= {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
              state <= DONE;
`else
              acc   <= {{XLEN{1'b0}}, a_mag};
              state <= MUL;
`endif
            end
          end
          MUL, DIV: begin
            acc <= (state == MUL) ? mul_next : div_next;
            if (cnt == CNT_LAST) begin
              cnt   <= '0;
              state <= DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          DONE: begin
            result <= res_sel;
            valid  <= 1'b1;
            busy   <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
